mult_booth_seq: RTL and testbench
=================================

Name: mult_booth_seq

Overview:
Sequential radix-2 Booth multiplier that is the companion of the iterative divider in the CPU's mult/div unit. It takes two 32-bit operands on an `init` pulse and iterates one Booth step per clock. It writes the 64-bit product to `hi` (upper word) and `lo` (lower word), then pulses `done`. The control unit stalls on `busy` during MULT/MULTU and reads `hi`/`lo` through MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; the product is 2*WIDTH bits, split into `hi`/`lo`.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  multiplicand; sampled only on the accepting `init` edge.
- b  input  WIDTH  multiplier; sampled only on the accepting `init` edge.
- init  input  1  start request; accepted only in IDLE.
- stop  input  1  synchronous abort; returns to IDLE.
- hi  output  WIDTH  product bits [2W-1:W]; registered.
- lo  output  WIDTH  product bits [W-1:0]; registered.
- busy  output  1  high while in LOAD-accepted, RUN or FINISH.
- done  output  1  one-cycle pulse when `hi`/`lo` are updated.

Behaviour:
- Reset (rst=1, async):
  - state=IDLE; `hi`=0, `lo`=0, `busy`=0, `done`=0.
  - Internal accumulator, multiplier register and counter cleared.
- Internal registers:
  - M: W+1 bits, sign-extended `a`.
  - A: W+1-bit accumulator.
  - Q: W+1 bits, sign-extended `b`.
  - q_1: 1-bit Booth guard bit.
  - cnt: 6 bits.
- State IDLE, `init`=1, `stop`=0 at edge N:
  - M<=sext(a), Q<=sext(b), A<=0, q_1<=0, cnt<=W.
  - state<=RUN, `busy`<=1.
- State RUN, each edge:
  - Booth pair {Q[0],q_1}:
    - 01: A<=A+M.
    - 10: A<=A-M.
    - 00 or 11: A unchanged.
  - Then arithmetic right shift of {A,Q,q_1} by 1, with A's MSB replicated.
  - cnt<=cnt-1.
  - When cnt reaches 0 after the step, state<=FINISH.
  - All arithmetic is W+1 bits, so the most-negative operand (0x80000000) never overflows the accumulator.
- State FINISH, one edge:
  - {`hi`,`lo`} <= low 2W bits of {A[W-1:0],Q[W:1]}, i.e. the product.
  - `done`<=1 for exactly one cycle; `busy`<=0; state<=IDLE.
- Latency: `init` accepted at edge N gives product and `done` valid after edge N+W+1 (N+33 for W=32); `busy` is high over the same interval.
- `init` while `busy`=1: ignored; operands are not resampled and the run is not restarted.
- `stop`=1 in any state:
  - Next edge: state<=IDLE, `busy`<=0, `done`<=0.
  - `hi`/`lo` keep their previous values.
  - `stop` wins over a simultaneous `init`.
- `rst` mid-operation: immediate abort; all outputs go to their reset values.
- `hi`/`lo` hold their last product until the next FINISH or reset.
- `done`=0 in every cycle except the one following FINISH.
- Back-to-back: `init` may be asserted in the cycle where `done`=1 (state is already IDLE) and is accepted.

Optional Feature:
- Macro MULT_UNSIGNED_EN.
- Defined:
  - Extra input `is_unsigned` (1 bit), sampled with `init`.
  - When `is_unsigned`=1, M and Q are zero-extended to W+1 bits and cnt is loaded with W+1, giving one extra RUN step.
  - Latency becomes N+W+2; the product is the low 2W bits of the result.
  - When `is_unsigned`=0, behaviour is identical to signed mode.
- Undefined: the port is absent and all multiplies are signed two's-complement.

Test Plan:
- a=7, b=0xFFFFFFFD (-3), init at edge N -> `busy` for 33 cycles; after edge N+33, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, `done` pulses for 1 cycle.
- a=0x80000000, b=0x80000000 -> `hi`=0x40000000, `lo`=0x00000000 (accumulator overflow corner).
- a=0xFFFFFFFF, b=0xFFFFFFFF signed -> `hi`=0, `lo`=1; with MULT_UNSIGNED_EN and `is_unsigned`=1 -> `hi`=0xFFFFFFFE, `lo`=0x00000001, `done` one cycle later.
- Start 12345*678; assert `stop` at RUN cycle 10 -> `busy` falls next edge; no `done`; `hi`/`lo` keep the prior product.
- Start a multiply; re-assert `init` with new operands at cycle 5 -> ignored; the original product appears at N+33.
- Assert `rst` mid-RUN -> `hi`=`lo`=0, `busy`=`done`=0 immediately; a subsequent init of 3*4 gives `lo`=12, `hi`=0.

Source files
------------

// File: rtl/mult_booth_seq.sv
// mult_booth_seq: sequential radix-2 Booth multiplier; init->done in WIDTH+1 cycles (WIDTH+2 for unsigned).
// No backpressure: init is ignored while busy, stop aborts; MULT_UNSIGNED_EN adds the is_unsigned input.
module mult_booth_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             init,
  input  logic             stop,
`ifdef MULT_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]     m_r;
  logic [WIDTH:0]     acc_r;
  logic [WIDTH:0]     q_r;
  logic               q_1;
  logic [5:0]         cnt;
  logic               accept;
  logic               busy_nxt;
  logic               done_nxt;
  logic [WIDTH:0]     m_ld;
  logic [WIDTH:0]     q_ld;
  logic [5:0]         cnt_ld;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     acc_sh;
  logic [WIDTH:0]     q_sh;
  logic [2*WIDTH-1:0] prod;

`ifdef MULT_UNSIGNED_EN
  logic uns_r;

  // Unsigned operands are zero-extended and need one extra step to consume the zero sign bit.
  always_comb begin
    if (is_unsigned) begin
      m_ld   = {1'b0, a};
      q_ld   = {1'b0, b};
      cnt_ld = 6'(WIDTH + 1);
    end else begin
      m_ld   = {a[WIDTH-1], a};
      q_ld   = {b[WIDTH-1], b};
      cnt_ld = 6'(WIDTH);
    end
  end

  // After WIDTH+1 shifts the low product bits fill all of Q rather than Q[W:1].
  assign prod = uns_r ? {acc_r[WIDTH-2:0], q_r} : {acc_r[WIDTH-1:0], q_r[WIDTH:1]};
`else
  assign m_ld   = {a[WIDTH-1], a};
  assign q_ld   = {b[WIDTH-1], b};
  assign cnt_ld = 6'(WIDTH);
  assign prod   = {acc_r[WIDTH-1:0], q_r[WIDTH:1]};
`endif

  assign accept = (state == IDLE) && init && !stop;

  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (init) begin
            state_nxt = RUN;
            busy_nxt  = 1'b1;
          end
        end
        RUN: begin
          if (cnt <= 6'd1) state_nxt = FINISH;
        end
        FINISH: begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
        default: begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // One Booth step: add/subtract M per {Q[0],q_1}, then arithmetic shift of {A,Q,q_1}.
  always_comb begin
    case ({q_r[0], q_1})
      2'b01:   sum = acc_r + m_r;
      2'b10:   sum = acc_r - m_r;
      default: sum = acc_r;
    endcase
    acc_sh = {sum[WIDTH], sum[WIDTH:1]};
    q_sh   = {sum[0], q_r[WIDTH:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_r   <= '0;
      acc_r <= '0;
      q_r   <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
`ifdef MULT_UNSIGNED_EN
      uns_r <= 1'b0;
`endif
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (accept) begin
        m_r   <= m_ld;
        acc_r <= '0;
        q_r   <= q_ld;
        q_1   <= 1'b0;
        cnt   <= cnt_ld;
`ifdef MULT_UNSIGNED_EN
        uns_r <= is_unsigned;
`endif
      end else if ((state == RUN) && !stop) begin
        acc_r <= acc_sh;
        q_r   <= q_sh;
        q_1   <= q_r[0];
        cnt   <= cnt - 6'd1;
      end
      if ((state == FINISH) && !stop) begin
        hi <= prod[2*WIDTH-1:WIDTH];
        lo <= prod[WIDTH-1:0];
      end
      busy <= busy_nxt;
      done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed bench for mult_booth_seq: latency, sign corners, stop, ignored init, async reset, back-to-back.
module tb_mult_booth_seq;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        init;
  logic        stop;
`ifdef MULT_UNSIGNED_EN
  logic        is_unsigned;
`endif
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  mult_booth_seq #(.WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .b(b),
    .init(init),
    .stop(stop),
`ifdef MULT_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .hi(hi),
    .lo(lo),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with init for exactly one edge (the accepting edge N).
  task automatic start(input logic [31:0] av, input logic [31:0] bv);
    a    = av;
    b    = bv;
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; init = 1'b0; stop = 1'b0; a = '0; b = '0;
`ifdef MULT_UNSIGNED_EN
    is_unsigned = 1'b0;
`endif
    tick(); tick();
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h exp=%h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h exp=%h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_signed_basic();
    start(32'd7, 32'hFFFF_FFFD);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_start got=%b exp=1", busy); end
    repeat (32) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_n32 got=%b exp=1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_early got=%b exp=0", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done_n33 got=%b exp=1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_n33 got=%b exp=0", busy); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL basic_hi got=%h exp=%h", hi, 32'hFFFF_FFFF); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL basic_lo got=%h exp=%h", lo, 32'hFFFF_FFEB); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL basic_lo_hold got=%h exp=%h", lo, 32'hFFFF_FFEB); end
  endtask

  task automatic test_most_negative();
    start(32'h8000_0000, 32'h8000_0000);
    repeat (33) tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL minneg_done got=%b exp=1", done); end
    checks++; if (hi !== 32'h4000_0000) begin errors++; $display("FAIL minneg_hi got=%h exp=%h", hi, 32'h4000_0000); end
    checks++; if (lo !== 32'h0000_0000) begin errors++; $display("FAIL minneg_lo got=%h exp=%h", lo, 32'h0); end
    tick();
  endtask

  task automatic test_stop();
    // Prior product is 0x40000000_00000000 and must survive the abort.
    start(32'd12345, 32'd678);
    repeat (10) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done got=%b exp=0", done); end
    begin
      int dn = 0;
      for (int i = 0; i < 35; i++) begin
        tick();
        if (done === 1'b1) dn++;
      end
      checks++; if (dn !== 0) begin errors++; $display("FAIL stop_no_done got=%0d pulses exp=0", dn); end
    end
    checks++; if (hi !== 32'h4000_0000) begin errors++; $display("FAIL stop_hi_kept got=%h exp=%h", hi, 32'h4000_0000); end
    checks++; if (lo !== 32'h0000_0000) begin errors++; $display("FAIL stop_lo_kept got=%h exp=%h", lo, 32'h0); end
  endtask

  task automatic test_init_ignored();
    start(32'd7, 32'hFFFF_FFFD);
    repeat (5) tick();
    a = 32'd3; b = 32'd4; init = 1'b1;
    tick();
    init = 1'b0; a = 32'd9; b = 32'd9;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got=%b exp=1", busy); end
    repeat (26) tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ign_done_early got=%b exp=0", done); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done_n33 got=%b exp=1", done); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ign_hi got=%h exp=%h", hi, 32'hFFFF_FFFF); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL ign_lo got=%h exp=%h", lo, 32'hFFFF_FFEB); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_not_restarted got=%b exp=0", busy); end
  endtask

  task automatic test_rst_mid();
    start(32'd5, 32'd6);
    repeat (10) tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rstmid_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rstmid_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", done); end
    tick();
    rst = 1'b0;
    tick();
    start(32'd3, 32'd4);
    repeat (33) tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done_after got=%b exp=1", done); end
    checks++; if (lo !== 32'd12) begin errors++; $display("FAIL rstmid_lo_after got=%h exp=%h", lo, 32'd12); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL rstmid_hi_after got=%h exp=0", hi); end
    tick();
  endtask

  task automatic test_minus_one();
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (33) tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL m1_done got=%b exp=1", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL m1_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'h1) begin errors++; $display("FAIL m1_lo got=%h exp=1", lo); end
    tick();
`ifdef MULT_UNSIGNED_EN
    is_unsigned = 1'b1;
    start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    is_unsigned = 1'b0;
    repeat (33) tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL uns_done_n33 got=%b exp=0", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL uns_busy_n33 got=%b exp=1", busy); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL uns_done_n34 got=%b exp=1", done); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL uns_hi got=%h exp=%h", hi, 32'hFFFF_FFFE); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL uns_lo got=%h exp=%h", lo, 32'h1); end
    tick();
`endif
  endtask

  task automatic test_back_to_back();
    start(32'd12345, 32'd678);
    repeat (33) tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got=%b exp=1", done); end
    checks++; if (lo !== 32'h007F_B6F6) begin errors++; $display("FAIL b2b_lo1 got=%h exp=%h", lo, 32'h007F_B6F6); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL b2b_hi1 got=%h exp=0", hi); end
    start(32'hFFFF_FFFE, 32'd100000);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got=%b exp=1", busy); end
    repeat (33) tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done2 got=%b exp=1", done); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL b2b_hi2 got=%h exp=%h", hi, 32'hFFFF_FFFF); end
    checks++; if (lo !== 32'hFFFC_F2C0) begin errors++; $display("FAIL b2b_lo2 got=%h exp=%h", lo, 32'hFFFC_F2C0); end
    tick();
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_most_negative();
    test_stop();
    test_init_ignored();
    test_rst_mid();
    test_minus_one();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
